// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_pkg : opcode and jump-class encodings shared by if_stage and pc unit  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

    localparam logic [5:0] OP_BEQ  = 6'd32;
    localparam logic [5:0] OP_BNE  = 6'd33;
    localparam logic [5:0] OP_BLT  = 6'd34;
    localparam logic [5:0] OP_BLE  = 6'd35;
    localparam logic [5:0] OP_J    = 6'd40;
    localparam logic [5:0] OP_JAL  = 6'd41;
    localparam logic [5:0] OP_JR   = 6'd42;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [1:0] JON_NONE = 2'b00;
    localparam logic [1:0] JON_JUMP = 2'b01;
    localparam logic [1:0] JON_BR   = 2'b10;

    // Wrong-path slots fetched after a redirect of the given class
    function automatic logic [1:0] squash_len(input logic [1:0] jon);
        case (jon)
            JON_JUMP: squash_len = 2'd1;
            JON_BR:   squash_len = 2'd2;
            default:  squash_len = 2'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_jdec.sv
// +----------------------------------------------------------------------------+
// | if_jdec : combinational opcode -> jump-class decoder                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_jdec
    import pipe_pkg::*;
(
    input  logic [5:0] op,
    output logic [1:0] jon
);

    always_comb begin
        jon = JON_NONE;
        case (op)
            OP_J, OP_JAL:                          jon = JON_JUMP;
            OP_BEQ, OP_BNE, OP_BLT, OP_BLE, OP_JR: jon = JON_BR;
            default:                               jon = JON_NONE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// +----------------------------------------------------------------------------+
// | if_stage : instruction fetch and IF/ID register with jump decode and halt  |
// | Optional macro IF_SQUASH_EN: invalidate wrong-path slots after redirects   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_stage
    import pipe_pkg::*;
#(
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [31:0]        pc_in,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ir_out,
    output logic [31:0]        pc_id,
    output logic               valid_id,
    output logic [1:0]         jon_d,
    output logic [25:0]        addr_d,
    output logic               halted
);

    logic [31:0] r_pc_f;
    logic        r_fill;
    logic [31:0] r_ir;
    logic [31:0] r_pc_id;
    logic        r_valid;
    logic        r_halted;
    logic [1:0]  r_squash_cnt;

    logic [1:0]  w_jon_raw;
    logic        w_adv;
    logic        w_halt_req;
    logic        w_slot_valid;
    logic        w_unused_pc_hi;

    assign imem_addr      = pc_in[IMEM_AW-1:0];
    assign w_unused_pc_hi = ^pc_in[31:IMEM_AW];

    if_jdec u_jdec (
        .op  (r_ir[31:26]),
        .jon (w_jon_raw)
    );

    assign w_adv        = !stall && !r_halted;
    assign w_halt_req   = r_valid && (r_ir[31:26] == OP_HALT) && !stall && !r_halted;
    assign w_slot_valid = r_fill && (r_squash_cnt == 2'd0);

    // Gating on stall keeps a held redirect from being seen twice by the pc unit
    assign jon_d  = (r_valid && !stall && !r_halted) ? w_jon_raw : JON_NONE;
    assign addr_d = r_ir[25:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f <= 32'd0;
            r_fill <= 1'b0;
        end else if (!stall) begin
            r_pc_f <= pc_in;
            r_fill <= 1'b1;
        end
    end

    // The halt word stays in IF/ID so the frozen state points at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir    <= NOP_WORD;
            r_pc_id <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_adv && !w_halt_req) begin
            r_ir    <= w_slot_valid ? imem_rdata : NOP_WORD;
            r_pc_id <= r_pc_f;
            r_valid <= w_slot_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_req) begin
            r_halted <= 1'b1;
        end
    end

`ifdef IF_SQUASH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_squash_cnt <= 2'd0;
        end else if (w_adv) begin
            if (r_squash_cnt != 2'd0) begin
                r_squash_cnt <= r_squash_cnt - 2'd1;
            end else begin
                r_squash_cnt <= squash_len(jon_d);
            end
        end
    end
`else
    assign r_squash_cnt = 2'd0;
`endif

    assign ir_out   = r_ir;
    assign pc_id    = r_pc_id;
    assign valid_id = r_valid;
    assign halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// +----------------------------------------------------------------------------+
// | tb_if_stage : self-checking bench for if_stage (honours IF_SQUASH_EN)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_stage;

    localparam int          AW  = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] W_J    = {6'd40, 26'h40};
    localparam logic [31:0] W_BEQ  = {6'd32, 26'd5};
    localparam logic [31:0] W_BNE  = {6'd33, 26'd7};
    localparam logic [31:0] W_HALT = {6'd63, 26'd0};

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          stall = 1'b0;
    logic [31:0]   pc_in = 32'd0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir_out;
    logic [31:0]   pc_id;
    logic          valid_id;
    logic [1:0]    jon_d;
    logic [25:0]   addr_d;
    logic          halted;

    logic [31:0] imem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    if_stage #(.IMEM_AW(AW), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_in      (pc_in),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .pc_id      (pc_id),
        .valid_id   (valid_id),
        .jon_d      (jon_d),
        .addr_d     (addr_d),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[imem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc_f, m_ir, m_pcid, m_rdata;
    logic        m_fill, m_valid, m_halted;
    int          m_cnt;

    function automatic logic [1:0] spec_jon(input logic [31:0] w);
        int op;
        op = int'(w[31:26]);
        if (op == 40 || op == 41) return 2'b01;
        if ((op >= 32 && op <= 35) || op == 42) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_jon_now();
        return (m_valid && !stall && !m_halted) ? spec_jon(m_ir) : 2'b00;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [1:0] j;
        logic       hreq;
        logic       slot;
        if (rst) begin
            m_pc_f = 0; m_ir = NOP; m_pcid = 0; m_valid = 0;
            m_cnt = 0; m_halted = 0; m_fill = 0;
        end else begin
            j    = m_jon_now();
            hreq = m_valid && (m_ir[31:26] == 6'd63) && !stall;
            if (!stall) begin
                if (!m_halted) begin
                    if (!hreq) begin
                        slot    = m_fill && (m_cnt == 0);
                        m_ir    = slot ? m_rdata : NOP;
                        m_pcid  = m_pc_f;
                        m_valid = slot;
                    end
`ifdef IF_SQUASH_EN
                    if (m_cnt > 0)      m_cnt = m_cnt - 1;
                    else if (j == 2'b01) m_cnt = 1;
                    else if (j == 2'b10) m_cnt = 2;
`endif
                    if (hreq) m_halted = 1;
                end
                m_pc_f = pc_in;
                m_fill = 1;
            end
            m_rdata = imem[pc_in[AW-1:0]];
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ir_out",    ir_out,            m_ir);
            chk("pc_id",     pc_id,             m_pcid);
            chk("valid_id",  32'(valid_id),     32'(m_valid));
            chk("jon_d",     32'(jon_d),        32'(m_jon_now()));
            chk("addr_d",    32'(addr_d),       32'(m_ir[25:0]));
            chk("halted",    32'(halted),       32'(m_halted));
            chk("imem_addr", 32'(imem_addr),    32'(pc_in[AW-1:0]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input logic s);
        stall = s;
        @(posedge clk);
        @(negedge clk);
        if (!s) pc_in = pc_in + 1;
    endtask

    task automatic run_to(input int t);
        int k;
        k = 0;
        while (!(valid_id && pc_id == t) && k < 100) begin
            tick(1'b0);
            k++;
        end
        chk("reach_pc", pc_id, 32'(t));
    endtask

    task automatic refill_checks();
        tick(1'b0);
        chk("t1_valid0", 32'(valid_id), 32'd0);
        tick(1'b0);
        chk("t1_valid1", 32'(valid_id), 32'd1);
        chk("t1_ir100",  ir_out, 32'd100);
        chk("t1_pc0",    pc_id,  32'd0);
        tick(1'b0);
        chk("t1_ir101",  ir_out, 32'd101);
        chk("t1_pc1",    pc_id,  32'd1);
        tick(1'b0);
        chk("t1_ir102",  ir_out, 32'd102);
        chk("t1_valid2", 32'(valid_id), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ir"},     ir_out, NOP);
        chk({tag, "_pc"},     pc_id,  32'd0);
        chk({tag, "_valid"},  32'(valid_id), 32'd0);
        chk({tag, "_jon"},    32'(jon_d),    32'd0);
        chk({tag, "_halted"}, 32'(halted),   32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = 32'(i + 100);
        imem[10] = W_J;
        imem[20] = W_BEQ;
        imem[30] = W_BNE;
        imem[50] = W_HALT;

        #1 rst = 1'b1;
        #1 started = 1'b1;
        @(negedge clk);
        reset_checks("rst0");
        @(negedge clk);
        #2 rst = 1'b0;

        // Test 1: refill after reset
        refill_checks();

        // Test 2: absolute jump
        run_to(10);
        chk("t2_jon",   32'(jon_d),  32'd1);
        chk("t2_addr",  32'(addr_d), 32'h40);
        tick(1'b0);
        chk("t2_jon0",  32'(jon_d),  32'd0);
        chk("t2_slot1", 32'(valid_id), 32'd1);
        tick(1'b0);
`ifdef IF_SQUASH_EN
        chk("t2_sq_valid", 32'(valid_id), 32'd0);
        chk("t2_sq_ir",    ir_out, NOP);
`else
        chk("t2_ds_valid", 32'(valid_id), 32'd1);
        chk("t2_ds_pc",    pc_id, 32'd12);
`endif

        // Test 3: conditional branch
        run_to(20);
        chk("t3_jon", 32'(jon_d), 32'd2);
        tick(1'b0);
        chk("t3_jon0",  32'(jon_d), 32'd0);
        chk("t3_slot1", 32'(valid_id), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0);
`ifdef IF_SQUASH_EN
            chk("t3_sq_valid", 32'(valid_id), 32'd0);
            chk("t3_sq_ir",    ir_out, NOP);
`else
            chk("t3_ds_valid", 32'(valid_id), 32'd1);
            chk("t3_ds_pc",    pc_id, 32'(22 + i));
`endif
        end
        tick(1'b0);
        chk("t3_resume_valid", 32'(valid_id), 32'd1);
        chk("t3_resume_ir",    ir_out, 32'd124);

        // Test 4: branch held by stall
        run_to(30);
        stall = 1'b1;
        #1 chk("t4_jon_st", 32'(jon_d), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_jon_held", 32'(jon_d), 32'd0);
            chk("t4_ir_held",  ir_out, W_BNE);
        end
        stall = 1'b0;
        #1 chk("t4_jon_go", 32'(jon_d), 32'd2);
        tick(1'b0);
        chk("t4_jon_once", 32'(jon_d), 32'd0);
        chk("t4_pc_next",  pc_id, 32'd31);

        // Test 6: reset pulse with squash pending
        #2 rst = 1'b1;
        pc_in = 32'd0;
        #1 reset_checks("rst1");
        @(negedge clk);
        #2 rst = 1'b0;
        refill_checks();

        // Test 5: halt
        run_to(50);
        chk("t5_pre_halted", 32'(halted), 32'd0);
        tick(1'b0);
        chk("t5_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            chk("t5_ir_frozen", ir_out, W_HALT);
            chk("t5_pc_frozen", pc_id,  32'd50);
            chk("t5_jon_zero",  32'(jon_d), 32'd0);
            chk("t5_sticky",    32'(halted), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
